// File: rtl/hsem_lock_arb_pkg.sv
// Shared encodings for the HSEM lock arbiter: FSM states, request opcodes and error codes.
package hsem_lock_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OP_LOCK   = 1'b1;
    localparam logic OP_UNLOCK = 1'b0;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_NOTOWN = 2'b01;
    localparam logic [1:0] ERR_TMO    = 2'b10;

endpackage

// File: rtl/hsem_rr_arb.sv
// Combinational round-robin picker: first active request at or above ptr_i, wrapping upward.
module hsem_rr_arb #(
    parameter int NREQ = 2,
    localparam int OW = $clog2((NREQ > 2) ? NREQ : 2)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [OW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [OW-1:0]   gnt_idx_o
);

    logic          found_s;
    logic [OW-1:0] cand_s;

    // Scan candidates starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = ((32'(ptr_i) + 32'(i)) >= 32'(NREQ)) ?
                     OW'(32'(ptr_i) + 32'(i) - 32'(NREQ)) : OW'(32'(ptr_i) + 32'(i));
            if (!found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                gnt_o[cand_s]  = 1'b1;
                gnt_idx_o      = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/hsem_lock_arb.sv
// HSEM ownership arbiter: round-robin lock/unlock service, per-semaphore owner state,
// hold-timeout forced release and per-requester error pulses.
module hsem_lock_arb
    import hsem_lock_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int NSEM   = 8,
    parameter int TMO_W  = 10,
    parameter int TMO_EN = 1,
    localparam int OW = $clog2((NREQ > 2) ? NREQ : 2),
    localparam int SW = $clog2(NSEM)
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*SW-1:0]   req_id,
    output logic [NREQ-1:0]      resp_valid,
    output logic                 resp_ok,
    input  logic                 clr_all,
    output logic [NSEM-1:0]      sem_locked,
    output logic [NSEM*OW-1:0]   sem_owner,
    output logic [NREQ-1:0]      err_pulse,
    output logic [1:0]           err_code
);

    state_e             state_q, state_d;
    logic [OW-1:0]      ptr_q, ptr_d, idx_q, idx_d;
    logic               op_q, op_d;
    logic [SW-1:0]      id_q, id_d;
    logic [NSEM-1:0]    locked_q, locked_d;
    logic [OW-1:0]      owner_q [NSEM];
    logic [OW-1:0]      owner_d [NSEM];
    logic [TMO_W-1:0]   cnt_q [NSEM];
    logic [TMO_W-1:0]   cnt_d [NSEM];
    logic [NREQ-1:0]    resp_valid_q, resp_valid_d, err_pulse_q, err_pulse_d;
    logic               resp_ok_q, resp_ok_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [NREQ-1:0]    gnt_s;
    logic [OW-1:0]      gnt_idx_s;
    logic               sel_op_s, tmo_fire_s, id_ok_s, cur_locked_s;
    logic [SW-1:0]      sel_id_s, tmo_sem_s;
    logic [OW-1:0]      cur_owner_s;

    hsem_rr_arb #(.NREQ(NREQ)) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s)
    );

    // Lowest saturated semaphore fires; the rest stay saturated for later cycles.
    always_comb begin
        tmo_fire_s = 1'b0;
        tmo_sem_s  = '0;
        for (int s = NSEM - 1; s >= 0; s--) begin
            if ((TMO_EN != 0) && locked_q[s] && (cnt_q[s] == {TMO_W{1'b1}})) begin
                tmo_fire_s = 1'b1;
                tmo_sem_s  = SW'(s);
            end else begin
                tmo_fire_s = tmo_fire_s;
            end
        end
    end

    // Winner's op/id, and the latched target's state after this cycle's timeout release.
    always_comb begin
        sel_op_s = 1'b0;
        sel_id_s = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_s[r]) begin
                sel_op_s = req_op[r];
                sel_id_s = req_id[r*SW +: SW];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
        id_ok_s      = (32'(id_q) < 32'(NSEM));
        cur_locked_s = locked_q[id_q] && !(tmo_fire_s && (tmo_sem_s == id_q));
        cur_owner_s  = cur_locked_s ? owner_q[id_q] : '0;
    end

    // Next-state: clr_all overrides everything, then timeout, then the FSM step.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        op_d         = op_q;
        id_d         = id_q;
        locked_d     = locked_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        resp_valid_d = '0;
        resp_ok_d    = 1'b0;
        err_pulse_d  = '0;
        err_code_d   = ERR_NONE;
        if (clr_all) begin
            state_d  = ST_IDLE;
            locked_d = '0;
            for (int s = 0; s < NSEM; s++) begin
                owner_d[s] = '0;
                cnt_d[s]   = '0;
            end
        end else begin
            for (int s = 0; s < NSEM; s++) begin
                if ((TMO_EN != 0) && locked_q[s] && (cnt_q[s] != {TMO_W{1'b1}})) begin
                    cnt_d[s] = cnt_q[s] + TMO_W'(1);
                end else begin
                    cnt_d[s] = cnt_q[s];
                end
            end
            if (tmo_fire_s) begin
                locked_d[tmo_sem_s]            = 1'b0;
                owner_d[tmo_sem_s]             = '0;
                cnt_d[tmo_sem_s]               = '0;
                err_pulse_d[owner_q[tmo_sem_s]] = 1'b1;
                err_code_d                     = ERR_TMO;
            end else begin
                err_code_d = ERR_NONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        idx_d   = gnt_idx_s;
                        op_d    = sel_op_s;
                        id_d    = sel_id_s;
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    state_d             = ST_RESP;
                    resp_valid_d[idx_q] = 1'b1;
                    if (!id_ok_s) begin
                        resp_ok_d = 1'b0;
                    end else if (op_q == OP_LOCK) begin
                        if (!cur_locked_s) begin
                            locked_d[id_q] = 1'b1;
                            owner_d[id_q]  = idx_q;
                            cnt_d[id_q]    = '0;
                            resp_ok_d      = 1'b1;
                        end else begin
                            resp_ok_d = (cur_owner_s == idx_q);
                        end
                    end else begin
                        if (cur_locked_s && (cur_owner_s == idx_q)) begin
                            locked_d[id_q] = 1'b0;
                            owner_d[id_q]  = '0;
                            cnt_d[id_q]    = '0;
                            resp_ok_d      = 1'b1;
                        end else if (cur_locked_s) begin
                            err_pulse_d[idx_q] = 1'b1;
                            err_code_d         = tmo_fire_s ? ERR_TMO : ERR_NOTOWN;
                        end else begin
                            resp_ok_d = 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    ptr_d   = (idx_q == OW'(NREQ - 1)) ? '0 : (idx_q + OW'(1));
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            op_q         <= 1'b0;
            id_q         <= '0;
            locked_q     <= '0;
            resp_valid_q <= '0;
            resp_ok_q    <= 1'b0;
            err_pulse_q  <= '0;
            err_code_q   <= ERR_NONE;
            for (int s = 0; s < NSEM; s++) begin
                owner_q[s] <= '0;
                cnt_q[s]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            id_q         <= id_d;
            locked_q     <= locked_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
        end
    end

    // Flatten the owner array onto the output bus.
    always_comb begin
        sem_owner = '0;
        for (int s = 0; s < NSEM; s++) begin
            sem_owner[s*OW +: OW] = owner_q[s];
        end
    end

    assign sem_locked = locked_q;
    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;

endmodule
